pwm_breath_decoder: RTL

Receive-side counterpart of the breathing-light PWM stage. Samples the 3-bit PWM-masked RGB line (rgb4 format: all enabled channels gated by one common mask, fixed-length frames starting with the mask high). Recovers per-frame duty (brightness level), the set of active colour channels, and the breathing direction. Used on the loop-back/monitor path to check and display the LED drive without an external analyser.

---
 rtl/pwm_breath_decoder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pwm_breath_decoder.sv
// Recovers per-frame duty level, colour set and breathing direction from a PWM-masked RGB line.
// Frame results appear two edges after the last sample of a frame is presented on rgb4_i.
module pwm_breath_decoder #(
  parameter int FRAME_LEN = 16,
  parameter int LVL_W     = $clog2(FRAME_LEN) + 1
) (
  input  logic             clk_div_i,
  input  logic             rst_i,
  input  logic [2:0]       rgb4_i,
  output logic [LVL_W-1:0] level_o,
  output logic [2:0]       color_o,
  output logic             valid_o,
  output logic             dir_o,
  output logic             dir_change_o,
  output logic             locked_o,
  output logic             sync_err_o
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  localparam logic [LVL_W-1:0] LAST_IDX = LVL_W'(FRAME_LEN - 1);
  localparam logic [LVL_W-1:0] ONE      = LVL_W'(1);

  state_t           state, state_nxt;
  logic [2:0]       r_in;
  logic             line, line_d, rise;
  logic [LVL_W-1:0] idx, hi_cnt, cnt_sum;
  logic [2:0]       col_acc, col_sum;
  logic             prev_vld;
  logic             restart, accum, frame_end, err;

  assign line    = |r_in;
  assign rise    = line & ~line_d;
  assign cnt_sum = hi_cnt + LVL_W'(line);
  assign col_sum = col_acc | r_in;

  always_ff @(posedge clk_div_i or posedge rst_i) begin
    if (rst_i) state <= UNLOCKED;
    else       state <= state_nxt;
  end

  // restart: current sample becomes idx 0; accum: sample joins the running frame
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    accum     = 1'b0;
    frame_end = 1'b0;
    err       = 1'b0;
    case (state)
      UNLOCKED: begin
        if (rise) begin
          restart   = 1'b1;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (rise && idx != '0) begin
          err     = 1'b1;
          restart = 1'b1;
        end else if (idx == '0) begin
          restart = 1'b1;
        end else begin
          accum     = 1'b1;
          frame_end = (idx == LAST_IDX);
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_div_i or posedge rst_i) begin
    if (rst_i) begin
      r_in         <= '0;
      line_d       <= 1'b0;
      idx          <= '0;
      hi_cnt       <= '0;
      col_acc      <= '0;
      prev_vld     <= 1'b0;
      level_o      <= '0;
      color_o      <= '0;
      valid_o      <= 1'b0;
      dir_o        <= 1'b0;
      dir_change_o <= 1'b0;
      locked_o     <= 1'b0;
      sync_err_o   <= 1'b0;
    end else begin
      r_in         <= rgb4_i;
      line_d       <= line;
      valid_o      <= frame_end;
      sync_err_o   <= err;
      dir_change_o <= 1'b0;
      locked_o     <= (state_nxt == LOCKED);

      if (restart) begin
        hi_cnt  <= LVL_W'(line);
        col_acc <= r_in;
        idx     <= ONE;
      end else if (accum) begin
        hi_cnt  <= cnt_sum;
        col_acc <= col_sum;
        idx     <= frame_end ? '0 : idx + ONE;
      end

      // level_o still holds the previously reported level, so it doubles as prev
      if (frame_end) begin
        level_o  <= cnt_sum;
        color_o  <= col_sum;
        prev_vld <= 1'b1;
        if (prev_vld) begin
          if (cnt_sum > level_o && !dir_o) begin
            dir_o        <= 1'b1;
            dir_change_o <= 1'b1;
          end else if (cnt_sum < level_o && dir_o) begin
            dir_o        <= 1'b0;
            dir_change_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule
